// File: rtl/aes_pkg.sv
// Shared constants, FSM encoding and byte/word helpers for the AES-128 key schedule.
// The S-box table lives here so the per-byte module and any word-level helper share one copy.
package aes_pkg;

    localparam int WORD        = 32;
    localparam int NK          = 4;
    localparam int NR          = 10;
    localparam int NB_WORDS    = 4;
    localparam int KEY_BITS    = 128;
    localparam int SCHED_WORDS = NB_WORDS * (NR + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } state_e;

    // Forward S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Byte k sits at bits [8*(255-k)+7 -: 8], i.e. index {~k, 3'b111}.
    function automatic logic [7:0] sbox_byte(input logic [7:0] b);
        return SBOX_TABLE[{~b, 3'b111} -: 8];
    endfunction

    function automatic logic [WORD-1:0] rot_word(input logic [WORD-1:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [WORD-1:0] sub_word(input logic [WORD-1:0] w);
        return {sbox_byte(w[31:24]), sbox_byte(w[23:16]),
                sbox_byte(w[15:8]),  sbox_byte(w[7:0])};
    endfunction

endpackage

// File: rtl/aes_rcon.sv
// Round-constant lookup; rcon in the top byte, lower bytes zero. Out-of-range rounds give 0.
module aes_rcon (
    input  logic [3:0]  round_number_i,
    output logic [31:0] rcon_out_o
);

    logic [7:0] rc;

    always_comb begin
        rc = 8'h00;
        unique case (round_number_i)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
    end

    assign rcon_out_o = {rc, 24'h000000};

endmodule

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box, one byte.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    assign out_o = sbox_byte(in_i);

endmodule

// File: rtl/aes_key_expansion.sv
// Iterative AES-128 key schedule: one word per clock into a 44-word flop array,
// with a registered 128-bit round-key read port.
module aes_key_expansion
    import aes_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [KEY_BITS-1:0] key_in,
    input  logic [3:0]          rk_addr,
    output logic [KEY_BITS-1:0] rk_data,
    output logic                busy,
    output logic                key_ready
);

    state_e              state_q;
    logic [5:0]          i_q;
    logic [WORD-1:0]     w_q [SCHED_WORDS];
    logic                busy_q;
    logic                key_ready_q;
    logic [KEY_BITS-1:0] rk_data_q;

    logic [5:0]      prev_idx, old_idx;
    logic [WORD-1:0] prev_w, rot_w, sub_w, rcon_w, temp_w, w_d;
    logic [3:0]      round_number;

    // Outside EXPAND i_q may be 0; pin the indices so the array is never read out of range.
    assign prev_idx = (state_q == EXPAND) ? i_q - 6'd1 : 6'd0;
    assign old_idx  = (state_q == EXPAND) ? i_q - 6'd4 : 6'd0;
    assign prev_w   = w_q[prev_idx];
    assign rot_w    = rot_word(prev_w);

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .in_i  (rot_w[8*b +: 8]),
            .out_o (sub_w[8*b +: 8])
        );
    end

    assign round_number = (state_q == EXPAND) ? i_q[5:2] : 4'd1;

    aes_rcon u_rcon (
        .round_number_i (round_number),
        .rcon_out_o     (rcon_w)
    );

    assign temp_w = (i_q[1:0] == 2'b00) ? (sub_w ^ rcon_w) : prev_w;
    assign w_d    = w_q[old_idx] ^ temp_w;

    logic       rd_valid;
    logic [5:0] rd_base;
    logic [KEY_BITS-1:0] rk_data_d;

    assign rd_valid  = (rk_addr <= 4'(NR));
    assign rd_base   = rd_valid ? {rk_addr, 2'b00} : 6'd0;
    assign rk_data_d = rd_valid ? {w_q[rd_base], w_q[rd_base + 6'd1],
                                   w_q[rd_base + 6'd2], w_q[rd_base + 6'd3]}
                                : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            i_q         <= 6'd0;
            busy_q      <= 1'b0;
            key_ready_q <= 1'b0;
            rk_data_q   <= '0;
            for (int k = 0; k < SCHED_WORDS; k++) begin
                w_q[k] <= '0;
            end
        end else begin
            rk_data_q <= rk_data_d;
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        for (int k = 0; k < NK; k++) begin
                            w_q[k] <= key_in[KEY_BITS-1-WORD*k -: WORD];
                        end
                        i_q         <= 6'(NK);
                        busy_q      <= 1'b1;
                        key_ready_q <= 1'b0;
                        state_q     <= EXPAND;
                    end
                end
                EXPAND: begin
                    // start is deliberately not looked at here.
                    w_q[i_q] <= w_d;
                    i_q      <= i_q + 6'd1;
                    if (i_q == 6'(SCHED_WORDS - 1)) begin
                        busy_q      <= 1'b0;
                        key_ready_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rk_data   = rk_data_q;
    assign busy      = busy_q;
    assign key_ready = key_ready_q;

endmodule

// File: tb/tb_aes_key_expansion.sv
// Directed bench for the AES-128 key schedule: FIPS-197 vectors, read-port boundaries,
// ignored start, mid-expansion reset and back-to-back restart; reads checked by a scoreboard.
module tb_aes_key_expansion;

    localparam logic [127:0] KEY_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] A1_R1    = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] A1_R10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KEY_ZERO = 128'h0;
    localparam logic [127:0] Z_R1     = 128'h62636363626363636263636362636363;
    localparam logic [127:0] Z_R10    = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    localparam logic [127:0] KEY_OTH  = 128'h000102030405060708090a0b0c0d0e0f;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic [3:0]   rk_addr;
    logic [127:0] rk_data;
    logic         busy;
    logic         key_ready;

    aes_key_expansion dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_in    (key_in),
        .rk_addr   (rk_addr),
        .rk_data   (rk_data),
        .busy      (busy),
        .key_ready (key_ready)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [127:0] exp_q [$];
    string        name_q [$];
    logic         rd_issue = 1'b0;
    logic         rd_pend  = 1'b0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // A read issued before edge P lands in rk_data at P; compare on the following negedge.
    always @(posedge clk) rd_pend <= rd_issue;

    always @(negedge clk) begin : monitor
        logic [127:0] e;
        string        n;
        if (rd_pend) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL read_unexpected actual=%h expected=none", rk_data);
            end else begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                check(n, rk_data, e);
            end
        end
    end

    task automatic rd(input string nm, input logic [3:0] addr, input logic [127:0] exp);
        rk_addr  = addr;
        exp_q.push_back(exp);
        name_q.push_back(nm);
        rd_issue = 1'b1;
        @(posedge clk);
        #1;
        rd_issue = 1'b0;
    endtask

    task automatic start_exp(input string nm, input logic [127:0] key);
        start  = 1'b1;
        key_in = key;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({nm, "_busy_after_E0"}, 128'(busy), 128'd1);
        check({nm, "_ready_low_after_E0"}, 128'(key_ready), 128'd0);
    endtask

    // Counts edges after E0 until key_ready; optionally pulses start (other key) before edge inj+1.
    task automatic wait_ready(input string nm, input int inj);
        int n = 0;
        while (!key_ready && n < 60) begin
            if (n == inj) begin
                start  = 1'b1;
                key_in = KEY_OTH;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            n++;
        end
        check({nm, "_latency"}, 128'(n), 128'd40);
        check({nm, "_busy_low_at_done"}, 128'(busy), 128'd0);
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        key_in  = '0;
        rk_addr = 4'd0;
        @(posedge clk);
        #1;
        check("reset_busy", 128'(busy), 128'd0);
        check("reset_key_ready", 128'(key_ready), 128'd0);
        check("reset_rk_data", rk_data, 128'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rd("reset_storage_r0", 4'd0, 128'd0);

        // FIPS-197 A.1
        start_exp("a1", KEY_A1);
        wait_ready("a1", -1);
        rd("a1_r1", 4'd1, A1_R1);
        rd("a1_r10", 4'd10, A1_R10);
        rd("a1_r0", 4'd0, KEY_A1);
        rd("a1_addr11", 4'd11, 128'd0);
        rd("a1_addr15", 4'd15, 128'd0);
        rd("a1_r1_again", 4'd1, A1_R1);

        // start during expansion must be ignored
        start_exp("ign", KEY_A1);
        wait_ready("ign", 9);
        rd("ign_r10", 4'd10, A1_R10);
        rd("ign_r0", 4'd0, KEY_A1);

        // reset in the middle of expansion
        start_exp("rst", KEY_A1);
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_busy", 128'(busy), 128'd0);
        check("midrst_key_ready", 128'(key_ready), 128'd0);
        check("midrst_rk_data", rk_data, 128'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rd("midrst_r0_cleared", 4'd0, 128'd0);
        rd("midrst_r10_cleared", 4'd10, 128'd0);
        check("midrst_no_ready", 128'(key_ready), 128'd0);

        start_exp("zero", KEY_ZERO);
        wait_ready("zero", -1);
        rd("zero_r10", 4'd10, Z_R10);

        // back-to-back: A.1 to DONE, then restart with the zero key
        start_exp("b2b_a1", KEY_A1);
        wait_ready("b2b_a1", -1);
        rd("b2b_a1_r10", 4'd10, A1_R10);
        start_exp("b2b_zero", KEY_ZERO);
        wait_ready("b2b_zero", -1);
        rd("b2b_zero_r1", 4'd1, Z_R1);
        rd("b2b_zero_r10", 4'd10, Z_R10);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 128'(exp_q.size()), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
